// File: rtl/a51_phase_sequencer_if.sv
// Handshake and status bundle between the A5/1 phase sequencer and its controller.
// The master side drives START/ENABLE/ABORT; the sequencer answers with strobes and counters.
interface a51_phase_sequencer_if #(
  parameter int CW = 8,
  parameter int TW = 10
);
  logic          START;
  logic          ENABLE;
  logic          ABORT;
  logic          STAGEONE;
  logic          STAGETWO;
  logic          STAGETHREE;
  logic          OUTPUTSTAGE;
  logic          DONE;
  logic          BUSY;
  logic [2:0]    PHASE;
  logic [CW-1:0] PCOUNT;
  logic          PHASE_LAST;
  logic [TW-1:0] Q;

  modport master (
    output START, ENABLE, ABORT,
    input  STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE, BUSY,
    input  PHASE, PCOUNT, PHASE_LAST, Q
  );

  modport slave (
    input  START, ENABLE, ABORT,
    output STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE, DONE, BUSY,
    output PHASE, PCOUNT, PHASE_LAST, Q
  );
endinterface

// File: rtl/a51_phase_sequencer.sv
// Phase sequencer for the A5/1 keystream core: KEY -> FRAME -> MIX -> OUT -> DONE
// with per-cycle stall, abort and one-hot stage strobes decoded from registers.
module a51_phase_sequencer #(
  parameter int KEY_LEN   = 64,
  parameter int FRAME_LEN = 22,
  parameter int MIX_LEN   = 100,
  parameter int OUT_LEN   = 228,
  parameter int CW        = 8,
  parameter int TW        = 10
) (
  input  logic                   C,
  input  logic                   CLR,
  a51_phase_sequencer_if.slave   bus
);

  localparam int MAX_LEN_A = (KEY_LEN > FRAME_LEN) ? KEY_LEN : FRAME_LEN;
  localparam int MAX_LEN_B = (MIX_LEN > OUT_LEN) ? MIX_LEN : OUT_LEN;
  localparam int MAX_LEN   = (MAX_LEN_A > MAX_LEN_B) ? MAX_LEN_A : MAX_LEN_B;
  localparam int TOTAL_LEN = KEY_LEN + FRAME_LEN + MIX_LEN + OUT_LEN;

  // Illegal lengths or counter widths must stop elaboration rather than wrap silently.
  if (KEY_LEN < 1 || FRAME_LEN < 1 || MIX_LEN < 1 || OUT_LEN < 1) begin : g_bad_len
    $error("a51_phase_sequencer: every phase length must be >= 1");
  end
  if ((longint'(1) << CW) <= longint'(MAX_LEN)) begin : g_bad_cw
    $error("a51_phase_sequencer: CW too narrow for the longest phase");
  end
  if ((longint'(1) << TW) <= longint'(TOTAL_LEN)) begin : g_bad_tw
    $error("a51_phase_sequencer: TW too narrow for the total sequence length");
  end

  localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] MIX_LAST   = CW'(MIX_LEN - 1);
  localparam logic [CW-1:0] OUT_LAST   = CW'(OUT_LEN - 1);

  // Encoding equals the PHASE output value so PHASE is the state register itself.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_FRAME = 3'd2,
    S_MIX   = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pcount_q, pcount_d;
  logic [TW-1:0] q_q, q_d;

  logic [CW-1:0] last_cnt;
  state_t        follow_state;
  logic          active;
  logic          phase_last;
  logic [4:0]    stage_vec;

  always_comb begin
    last_cnt     = '0;
    follow_state = S_IDLE;
    case (state_q)
      S_KEY:   begin last_cnt = KEY_LAST;   follow_state = S_FRAME; end
      S_FRAME: begin last_cnt = FRAME_LAST; follow_state = S_MIX;   end
      S_MIX:   begin last_cnt = MIX_LAST;   follow_state = S_OUT;   end
      S_OUT:   begin last_cnt = OUT_LAST;   follow_state = S_DONE;  end
      default: begin last_cnt = '0;         follow_state = S_IDLE;  end
    endcase
  end

  assign active     = (state_q == S_KEY) || (state_q == S_FRAME) ||
                      (state_q == S_MIX) || (state_q == S_OUT);
  assign phase_last = active && (pcount_q == last_cnt);

  // Bit gi is high in the state whose encoding is gi+1 (KEY..DONE).
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    assign stage_vec[gi] = (state_q == state_t'(3'(gi + 1)));
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      pcount_q <= '0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      pcount_q <= pcount_d;
      q_q      <= q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcount_d = pcount_q;
    q_d      = q_q;
    if (!active) begin
      if (bus.START) begin
        state_d  = S_KEY;
        pcount_d = '0;
        q_d      = '0;
      end
    end else if (bus.ABORT) begin
      // Q deliberately keeps its value so software can see how far the run got.
      state_d  = S_IDLE;
      pcount_d = '0;
    end else if (bus.ENABLE) begin
      q_d = q_q + TW'(1);
      if (phase_last) begin
        state_d  = follow_state;
        pcount_d = '0;
      end else begin
        pcount_d = pcount_q + CW'(1);
      end
    end
  end

  always_comb begin
    bus.STAGEONE    = stage_vec[0];
    bus.STAGETWO    = stage_vec[1];
    bus.STAGETHREE  = stage_vec[2];
    bus.OUTPUTSTAGE = stage_vec[3];
    bus.DONE        = stage_vec[4];
    bus.BUSY        = |stage_vec[3:0];
    bus.PHASE       = state_q;
    bus.PCOUNT      = pcount_q;
    bus.PHASE_LAST  = phase_last;
    bus.Q           = q_q;
  end

endmodule
